xintf_zynq_port_arbiter: RTL
============================

Name: xintf_zynq_port_arbiter

Overview:
Shares the Zynq-side port of the XINTF DPBRAM (9-bit address, 16-bit data, 1-cycle registered read) between three requesters: 0 = EPICS write-index path, 1 = read-back scanner, 2 = waveform loader. It uses a round-robin grant, completes one access at a time and returns write/read completion through a per-requester req/ack handshake. A lock input blocks new grants while the DSP XINTF transfer window is active. It sits between the requester logic and the M_XINTF_PL_DPBRAM pins, replacing direct drive of those pins.

Parameters:
ADDR_W, 9, DPBRAM address width
DATA_W, 16, DPBRAM data width
LOCK_EN, 1, 1 = honour i_lock; 0 = ignore i_lock

Ports:
i_clk  in  1  system clock (s00_axi_aclk domain)
i_rst  in  1  synchronous reset, active-high
i_lock  in  1  DSP window active; no new grant while high
i_req  in  3  access request per requester; held until ack
i_we  in  3  1 = write, 0 = read, per requester
i_addr  in  3*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W]
i_din  in  3*DATA_W  packed write data, same packing
o_ack  out  3  one-cycle completion pulse per requester
o_rdata  out  DATA_W  read data; valid in the ack cycle of a read
o_busy  out  1  access in flight (state != IDLE)
o_grant_id  out  2  index of the current/last grant
o_contend_cnt  out  16  saturating count of IDLE cycles with ≥2 eligible requests
o_xintf_PL_ram_addr  out  ADDR_W  DPBRAM address
o_xintf_PL_ram_ce  out  1  DPBRAM enable
o_xintf_PL_ram_we  out  1  DPBRAM write enable
o_xintf_PL_ram_din  out  DATA_W  DPBRAM write data
i_xintf_PL_ram_dout  in  DATA_W  DPBRAM read data (valid 1 cycle after ce)

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE; all outputs 0; RR pointer = 2, so requester 0 has first priority. Reset mid-access aborts it with no ack, and ram_ce/we drop on the next cycle.
- Eligible(k) = i_req[k] & ~o_ack[k]. This stops a requester that is still holding req during its own ack cycle from being granted again.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - If (~i_lock | ~LOCK_EN) and any requester is eligible, pick the first eligible requester in order ptr+1, ptr+2, ptr (mod 3).
  - Register grant_id, ram_addr, ram_din and ram_we = i_we[g], set ram_ce = 1, set ptr = g, and go to ACCESS.
  - Otherwise ram_ce = ram_we = 0.
- ACCESS (1 cycle, ram_ce high):
  - Write: next cycle ram_ce = ram_we = 0, o_ack[g] = 1, state IDLE.
  - Read: next cycle ram_ce = 0, state RDWAIT.
- RDWAIT (1 cycle): capture i_xintf_PL_ram_dout into o_rdata, set o_ack[g] = 1, state IDLE.
- Latency from req sampled in IDLE at cycle t:
  - Write: ce/we high in t+1, ack in t+2.
  - Read: ce high in t+1, ack and rdata in t+3.
  - Back-to-back: the next grant can be issued in the ack cycle, so there is no idle bubble beyond the ack cycle.
- o_rdata holds its value until the next read completes; writes do not change it.
- i_lock:
  - Sampled only in IDLE.
  - An access already in ACCESS or RDWAIT completes normally even if lock rises.
  - A pending grant is issued on the first IDLE cycle with lock low.
- Requester contract: addr/we/din stable from req rise to ack; req may drop in the ack cycle. Dropping req before ack is illegal (undefined).
- o_contend_cnt: +1 on each IDLE cycle with ≥2 eligible requests, regardless of lock. Saturates at 16'hFFFF; cleared only by reset.
- Simultaneous events:
  - All three requesting continuously: grants go strictly 0,1,2,0,… with no starvation; worst-case wait is 2 accesses.
  - Reset wins over everything.

Test Plan:
- Reset, then req0 write (addr 0x010, din 0xA5A5) -> ce=we=1 with addr 0x010 at t+1; ack[0] at t+2; a model BRAM holds 0xA5A5.
- req1 read of addr 0x010 -> ce at t+1, we=0; ack[1] at t+3 with o_rdata=0xA5A5.
- req0, req1, req2 all held continuously (reads) -> grant order 0,1,2,0,1,2; each ack 3 cycles apart with no bubble; o_contend_cnt increments on each grant cycle where ≥2 remain eligible.
- i_lock=1 while req2 is pending -> no ce for 20 cycles; lock falls -> ce the next cycle, ack[2] 2 or 3 cycles later per op; lock rising during ACCESS -> that access still acks.
- i_rst pulsed in RDWAIT of a read -> no ack, all outputs 0 next cycle; after release, req0 and req2 pending together -> req0 granted first.
- Force o_contend_cnt to 16'hFFFE, then 3 contended IDLE cycles -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/xintf_zynq_port_arbiter.sv
// Round-robin arbiter sharing the Zynq-side DPBRAM port between three requesters.
// One access in flight at a time; completion is returned as a one-cycle ack per requester.
module xintf_zynq_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 16,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_lock,
    input  logic [2:0]            i_req,
    input  logic [2:0]            i_we,
    input  logic [3*ADDR_W-1:0]   i_addr,
    input  logic [3*DATA_W-1:0]   i_din,
    output logic [2:0]            o_ack,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_busy,
    output logic [1:0]            o_grant_id,
    output logic [15:0]           o_contend_cnt,
    output logic [ADDR_W-1:0]     o_xintf_PL_ram_addr,
    output logic                  o_xintf_PL_ram_ce,
    output logic                  o_xintf_PL_ram_we,
    output logic [DATA_W-1:0]     o_xintf_PL_ram_din,
    input  logic [DATA_W-1:0]     i_xintf_PL_ram_dout
);

    // state  | meaning
    // IDLE   | no access in flight; arbitrate when unlocked
    // ACCESS | ram_ce high for the granted requester
    // RDWAIT | read data returning from the RAM; capture and ack
    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                we_q, we_d;
    logic                ce_q, ce_d;
    logic [2:0]          ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [2:0]          elig;
    logic                contend;
    logic [1:0]          pick;
    logic                pick_vld;
    logic [1:0]          cand;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A requester still holding req in its own ack cycle must not win again.
    assign elig    = i_req & ~ack_q;
    assign contend = (elig[0] & elig[1]) | (elig[0] & elig[2]) | (elig[1] & elig[2]);

    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        cand     = rr_next(ptr_q);
        for (int i = 0; i < 3; i++) begin
            if (!pick_vld && elig[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
            cand = rr_next(cand);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = 1'b0;
        ce_d    = 1'b0;
        ack_d   = 3'b000;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (contend && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                if ((!i_lock || !LOCK_EN) && pick_vld) begin
                    grant_d = pick;
                    ptr_d   = pick;
                    addr_d  = i_addr[pick*ADDR_W +: ADDR_W];
                    din_d   = i_din[pick*DATA_W +: DATA_W];
                    we_d    = i_we[pick];
                    ce_d    = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    ack_d   = 3'b001 << grant_q;
                    state_d = IDLE;
                end else begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                rdata_d = i_xintf_PL_ram_dout;
                ack_d   = 3'b001 << grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd2;
            grant_q <= 2'd0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            ce_q    <= 1'b0;
            ack_q   <= 3'b000;
            rdata_q <= '0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            ce_q    <= ce_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ack               = ack_q;
    assign o_rdata             = rdata_q;
    assign o_busy              = (state_q != IDLE);
    assign o_grant_id          = grant_q;
    assign o_contend_cnt       = cnt_q;
    assign o_xintf_PL_ram_addr = addr_q;
    assign o_xintf_PL_ram_ce   = ce_q;
    assign o_xintf_PL_ram_we   = we_q;
    assign o_xintf_PL_ram_din  = din_q;

endmodule
